// File: rtl/mips_bus_arbiter_if.sv
// Requester-side and memory-bus-side signal bundle for mips_bus_arbiter.
// master: arbiter view (drives bus strobes and responses); slave: requesters and memory.
interface mips_bus_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int BE = DW / 8;

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_write;
  logic [NCH*AW-1:0] req_address;
  logic [NCH*DW-1:0] req_writedata;
  logic [NCH*BE-1:0] req_byteenable;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    rsp_valid;
  logic [DW-1:0]     rsp_readdata;
  logic              busy;

  logic [AW-1:0]     address;
  logic              read;
  logic              write;
  logic [DW-1:0]     writedata;
  logic [BE-1:0]     byteenable;
  logic [DW-1:0]     readdata;
  logic              waitrequest;

  modport master (
    input  req_valid,
    input  req_write,
    input  req_address,
    input  req_writedata,
    input  req_byteenable,
    output req_ready,
    output rsp_valid,
    output rsp_readdata,
    output busy,
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  readdata,
    input  waitrequest
  );

  modport slave (
    output req_valid,
    output req_write,
    output req_address,
    output req_writedata,
    output req_byteenable,
    input  req_ready,
    input  rsp_valid,
    input  rsp_readdata,
    input  busy,
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output readdata,
    input  waitrequest
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// NCH-channel fixed/round-robin arbiter onto a single Avalon-style bus.
// Ports: clk, reset (async active-low), bus (mips_bus_arbiter_if.master).
module mips_bus_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int RR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  mips_bus_arbiter_if.master  bus
);

  localparam int BE = DW / 8;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_owner;
  logic          r_wr;
  logic          r_read;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [BE-1:0] r_be;
  logic [NCH-1:0] r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;

  logic          w_done;
  logic          w_arb_en;
  logic [IW-1:0] w_start;
  logic          w_found;
  logic [IW-1:0] w_gidx;
  logic          w_grant;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [BE-1:0] w_sel_be;

  assign w_done   = (r_state == S_ACCESS) && !bus.waitrequest;
  // Reset gates the grant so req_ready drops as soon as reset asserts.
  assign w_arb_en = reset && ((r_state == S_IDLE) || w_done);
  assign w_grant  = w_arb_en && w_found;

  always_comb begin
    w_start = '0;
    if (RR != 0 && NCH > 1) begin
      if (r_last == IW'(NCH - 1))
        w_start = '0;
      else
        w_start = r_last + IW'(1);
    end
  end

  // Scan channels in priority order starting at w_start.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!w_found && bus.req_valid[i] &&
            ((int'(w_start) + k) % NCH == i)) begin
          w_found = 1'b1;
          w_gidx  = IW'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gidx == IW'(i)) begin
        w_sel_wr    = bus.req_write[i];
        w_sel_addr  = bus.req_address[i*AW +: AW];
        w_sel_wdata = bus.req_writedata[i*DW +: DW];
        w_sel_be    = bus.req_byteenable[i*BE +: BE];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NCH; i++)
      bus.req_ready[i] = w_grant && (w_gidx == IW'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NCH - 1);
      r_owner     <= '0;
      r_wr        <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_done) begin
        for (int i = 0; i < NCH; i++)
          r_rsp_valid[i] <= (r_owner == IW'(i));
        if (!r_wr)
          r_rsp_rdata <= bus.readdata;
      end
      // A grant in the completion cycle keeps the strobes up back-to-back.
      if (w_grant) begin
        r_state <= S_ACCESS;
        r_owner <= w_gidx;
        r_last  <= w_gidx;
        r_wr    <= w_sel_wr;
        r_read  <= !w_sel_wr;
        r_write <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
      end else if (w_done) begin
        r_state <= S_IDLE;
        r_read  <= 1'b0;
        r_write <= 1'b0;
      end
    end
  end

  assign bus.busy         = (r_state == S_ACCESS);
  assign bus.read         = r_read;
  assign bus.write        = r_write;
  assign bus.address      = r_addr;
  assign bus.writedata    = r_wdata;
  assign bus.byteenable   = r_be;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_readdata = r_rsp_rdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: NCH=2 fixed and NCH=3 round-robin.
// Directed vectors push expected responses; monitors pop on rsp_valid.
module tb_mips_bus_arbiter;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];

  mips_bus_arbiter_if #(.NCH(2), .AW(32), .DW(32)) b2();
  mips_bus_arbiter_if #(.NCH(3), .AW(32), .DW(32)) b3();

  mips_bus_arbiter #(.NCH(2), .AW(32), .DW(32), .RR(0)) dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b2.master)
  );

  mips_bus_arbiter #(.NCH(3), .AW(32), .DW(32), .RR(1)) dut3 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b3.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (|b2.rsp_valid) begin
      if (q2.size() == 0) begin
        chk("rsp2 unexpected", 64'(b2.rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("rsp2 chan", 64'(b2.rsp_valid), 64'(1) << e.ch);
        chk("rsp2 data", 64'(b2.rsp_readdata), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (|b3.rsp_valid) begin
      if (q3.size() == 0) begin
        chk("rsp3 unexpected", 64'(b3.rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("rsp3 chan", 64'(b3.rsp_valid), 64'(1) << e.ch);
        chk("rsp3 data", 64'(b3.rsp_readdata), 64'(e.data));
      end
    end
  end

  function automatic exp_t mk(input int ch, input logic [31:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    return e;
  endfunction

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    b2.req_valid      = '0;
    b2.req_write      = '0;
    b2.req_address    = '0;
    b2.req_writedata  = '0;
    b2.req_byteenable = '0;
    b2.readdata       = '0;
    b2.waitrequest    = 1'b0;
    b3.req_valid      = '0;
    b3.req_write      = '0;
    b3.req_address    = '0;
    b3.req_writedata  = '0;
    b3.req_byteenable = '0;
    b3.readdata       = '0;
    b3.waitrequest    = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset read",  64'(b2.read), 64'd0);
    chk("reset write", 64'(b2.write), 64'd0);
    chk("reset busy",  64'(b2.busy), 64'd0);
    chk("reset addr",  64'(b2.address), 64'd0);
    chk("reset rdy",   64'(b2.req_ready), 64'd0);
    rst_n = 1'b1;

    // Single read by ch0.
    @(negedge clk);
    b2.req_valid = 2'b01;
    b2.req_write = 2'b00;
    b2.req_address[31:0] = 32'hBFC00000;
    b2.readdata = 32'h8C020004;
    q2.push_back(mk(0, 32'h8C020004));
    #1;
    chk("t1 ready", 64'(b2.req_ready), 64'h1);
    @(negedge clk);
    b2.req_valid = 2'b00;
    #1;
    chk("t1 read", 64'(b2.read), 64'd1);
    chk("t1 addr", 64'(b2.address), 64'hBFC00000);

    // Write by ch1 with three wait cycles.
    @(negedge clk);
    b2.req_valid = 2'b10;
    b2.req_write = 2'b10;
    b2.req_address[63:32] = 32'h00001000;
    b2.req_writedata[63:32] = 32'hDEADBEEF;
    b2.req_byteenable[7:4] = 4'b0011;
    b2.waitrequest = 1'b1;
    b2.readdata = 32'h55555555;
    #1;
    chk("t2 ready", 64'(b2.req_ready), 64'h2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b2.req_valid = 2'b00;
      b2.waitrequest = (k < 3);
      if (k == 3) q2.push_back(mk(1, 32'h8C020004));
      #1;
      chk("t2 write", 64'(b2.write), 64'd1);
      chk("t2 addr",  64'(b2.address), 64'h1000);
      chk("t2 wdata", 64'(b2.writedata), 64'hDEADBEEF);
      chk("t2 be",    64'(b2.byteenable), 64'h3);
      chk("t2 nordy", 64'(b2.req_ready), 64'd0);
    end

    // Fixed priority starvation of ch1.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      b2.waitrequest = 1'b0;
      b2.req_write = 2'b00;
      b2.req_address = {32'h00000A10, 32'h00000A00};
      b2.req_valid = (k < 6) ? 2'b11 : 2'b00;
      b2.readdata = 32'h100 + 32'(k);
      if (k < 6) q2.push_back(mk(0, 32'h101 + 32'(k)));
      #1;
      if (k < 6) chk("t3 ready", 64'(b2.req_ready), 64'h1);
      if (k > 0) chk("t3 read", 64'(b2.read), 64'd1);
    end

    // Back-to-back hand-over from ch0 to ch1.
    @(negedge clk);
    b2.req_valid = 2'b01;
    b2.req_address = {32'h00000080, 32'h00000040};
    q2.push_back(mk(0, 32'h11111111));
    #1;
    chk("t5 ready0", 64'(b2.req_ready), 64'h1);
    @(negedge clk);
    b2.req_valid = 2'b10;
    b2.readdata = 32'h11111111;
    q2.push_back(mk(1, 32'h22222222));
    #1;
    chk("t5 ready1", 64'(b2.req_ready), 64'h2);
    chk("t5 read0",  64'(b2.read), 64'd1);
    chk("t5 addr0",  64'(b2.address), 64'h40);
    @(negedge clk);
    b2.req_valid = 2'b00;
    b2.readdata = 32'h22222222;
    #1;
    chk("t5 read1", 64'(b2.read), 64'd1);
    chk("t5 addr1", 64'(b2.address), 64'h80);
    @(negedge clk);
    #1;
    chk("t5 idle", 64'({b2.read, b2.busy}), 64'd0);

    // Round-robin, three channels.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b3.req_write = 3'b000;
      b3.req_address = {32'h3008, 32'h3004, 32'h3000};
      b3.req_valid = (k < 6) ? 3'b111 : 3'b000;
      b3.readdata = 32'h200 + 32'(k);
      if (k < 6) q3.push_back(mk(k % 3, 32'h201 + 32'(k)));
      #1;
      if (k < 6)
        chk("t4 ready", 64'(b3.req_ready), 64'(1) << (k % 3));
      if (k >= 2)
        chk("t4 rsp", 64'(b3.rsp_valid), 64'(1) << ((k - 2) % 3));
    end

    // Reset in the middle of a stalled access.
    @(negedge clk);
    b3.req_valid = 3'b010;
    b3.waitrequest = 1'b1;
    #1;
    chk("t6 ready1", 64'(b3.req_ready), 64'h2);
    @(negedge clk);
    b3.req_valid = 3'b000;
    #1;
    chk("t6 read", 64'(b3.read), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async", 64'({b3.read, b3.write, b3.busy}), 64'd0);
    @(negedge clk);
    #1;
    chk("t6 norsp", 64'(b3.rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b3.waitrequest = 1'b0;
    @(negedge clk);
    b3.req_valid = 3'b111;
    q3.push_back(mk(0, 32'h33));
    #1;
    chk("t6 ready0", 64'(b3.req_ready), 64'h1);
    @(negedge clk);
    b3.req_valid = 3'b000;
    b3.readdata = 32'h33;

    cyc = 0;
    while ((q2.size() + q3.size()) != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    #2;
    chk("drain", 64'(q2.size() + q3.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Parametrised N-channel master arbiter that multiplexes several internal requesters (instruction fetch, data load/store, future DMA/debug ports) onto the single Avalon-style memory bus (`address`/`read`/`write`/`writedata`/`byteenable`/`readdata`/`waitrequest`) driven by the CPU top level. It generalises the single fetch/data address mux to `NCH` channels with selectable fixed or round-robin priority. It registers each granted request, holds it stable under `waitrequest`, and returns a registered per-channel response. One transaction is outstanding on the bus at a time. Back-to-back transactions run with no idle cycle.

## Interface
Parameters:
- `NCH`, 2: number of requester channels (≥1); channel 0 is instruction fetch by convention.
- `AW`, 32: address width.
- `DW`, 32: data width, multiple of 8; `BE = DW/8`.
- `RR`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  NCH  channel i requests an access.
- `req_write`  in  NCH  1 = write, 0 = read.
- `req_address`  in  NCH*AW  channel i at bits [i*AW +: AW].
- `req_writedata`  in  NCH*DW  channel i at [i*DW +: DW].
- `req_byteenable`  in  NCH*BE  channel i at [i*BE +: BE].
- `req_ready`  out  NCH  one-hot pulse: request of channel i accepted this cycle.
- `rsp_valid`  out  NCH  one-hot pulse: transaction of channel i completed.
- `rsp_readdata`  out  DW  read data, valid with `rsp_valid` for reads.
- `busy`  out  1  a transaction is on the bus.
- `address`  out  AW  bus address.
- `read`  out  1  bus read strobe.
- `write`  out  1  bus write strobe.
- `writedata`  out  DW  bus write data.
- `byteenable`  out  BE  bus byte lanes.
- `readdata`  in  DW  bus read data, sampled when `read`=1 and `waitrequest`=0.
- `waitrequest`  in  1  slave stall; bus outputs must hold while 1.

## Operation
- States: IDLE (no bus transaction) and ACCESS (registered request on bus).
- Grant computation is combinational and runs when state is IDLE, or when state is ACCESS and `waitrequest`=0 (the completion cycle). Winner g is selected from the set of `req_valid` bits.
- Fixed mode: g = lowest set index. RR mode: search starts at `(last+1) mod NCH`, where `last` is the most recent granted channel. `last` resets to NCH-1, so channel 0 wins first.
- On grant: `req_ready[g]`=1 in the same cycle. Address, write, writedata and byteenable of g are latched. State is ACCESS next cycle. `last`←g.
- Requester protocol: hold `req_*` stable until `req_ready`. The accepted request is consumed on that edge. The next request, or `req_valid`=0, must appear in the following cycle.
- ACCESS: `read`=~w and `write`=w from the latch. `address`, `writedata` and `byteenable` come from the latch and are unchanged while `waitrequest`=1.
- Completion (ACCESS and `waitrequest`=0):
  - Next cycle `rsp_valid[owner]`=1 for one cycle.
  - For reads, `rsp_readdata`←`readdata`. For writes, `rsp_readdata` holds its previous value.
  - If a grant occurs in the same cycle, the new request is latched and state stays ACCESS. Otherwise state goes to IDLE.
- A channel may be re-granted in its own completion cycle.
- `byteenable` passes through unmodified, including all-zero. There is no alignment check.
- In IDLE: `read`=`write`=0, `busy`=0. `address`, `writedata` and `byteenable` hold their last values.

## Timing
- Reset (async, `reset`=0) immediately sets: state IDLE; `read`, `write`, `busy`, `req_ready`, `rsp_valid` all 0; `address`, `writedata`, `byteenable`, `rsp_readdata` all 0; `last`=NCH-1. An in-flight transaction is dropped with no response.
- Deassertion is synchronous to `clk` through the existing reset-release path. The first grant is possible in the first cycle after release.
- Latency: request in cycle t (idle bus) → `req_ready` at t → strobe at t+1 → with zero wait, `rsp_valid` and data at t+2. Each `waitrequest` cycle adds 1.
- Throughput: one transaction per cycle with zero-wait slave and continuous requests.
- `req_ready` is never asserted while state is ACCESS and `waitrequest`=1.
- `req_ready` and `rsp_valid` are each at most one-hot.
- NCH=1: arbitration degenerates to a pass-through. Fixed and RR modes behave identically.

## Test plan
- Single read, NCH=2, ch0 `req_address`=0xBFC00000, zero wait, `readdata`=0x8C020004 → `req_ready`=01 at t, `read`=1 with `address`=0xBFC00000 at t+1, `rsp_valid`=01 with `rsp_readdata`=0x8C020004 at t+2.
- Write by ch1 (addr 0x1000, data 0xDEADBEEF, be 0b0011), `waitrequest` high for 3 cycles → `write`, `address`, `writedata` and `byteenable` stay constant for 4 cycles; `rsp_valid`=10 one cycle after `waitrequest` falls; `rsp_readdata` unchanged.
- Fixed mode, ch0 and ch1 both requesting continuously, zero wait → ch0 granted every cycle and ch1 never granted (documented starvation).
- RR mode, NCH=3, all channels requesting continuously, zero wait → grants cycle 0,1,2,0,1,2; exactly one `rsp_valid` per cycle from t+2.
- Back-to-back: ch0 read completes while ch1 is requesting → `req_ready`=10 in the completion cycle, `read`/`write` never drop to 0, `address` switches to ch1's value on the next cycle.
- `reset`=0 asserted mid-ACCESS with `waitrequest`=1 → `read`/`write`/`busy` go to 0 without waiting for `clk`; no `rsp_valid` appears; after release, ch0 is granted first in RR mode.
